// File: rtl/nic_pkg.sv
// Shared constants and CPU access decoding for the NIC slice.
// Optional build macro: NIC_POLARITY_CHECK_EN (see rtl/nic.sv).
package nic_pkg;

  localparam int DEFAULT_PACKET_WIDTH = 64;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  // Virtual-channel bit position inside a packet (bit 0 is the MSB).
  localparam int VC_BIT = 0;

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'b00,
    CPU_LOAD  = 2'b01,
    CPU_STORE = 2'b10
  } cpu_op_e;

  function automatic cpu_op_e decode_op(input logic en, input logic wr);
    if (!en)    return CPU_IDLE;
    else if (wr) return CPU_STORE;
    else        return CPU_LOAD;
  endfunction

endpackage

// File: rtl/nic_channel_buf.sv
// Single-entry channel buffer: one packet register plus its full flag.
// A write loads the packet and sets full; a clear drops full but keeps the data.
module nic_channel_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [0:WIDTH-1] wr_data,
  input  logic             clr,
  output logic [0:WIDTH-1] data,
  output logic             full
);

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the data register is reset too, since its contents
  // are observable (stale loads) and must be zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      data <= wr_data;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/nic.sv
// NIC between a PE CPU port (2-bit memory map) and one mesh router PE port.
// Define NIC_POLARITY_CHECK_EN to gate injection on VC bit == net_polarity.
module nic
  import nic_pkg::*;
#(
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:1]              addr,
  input  logic [0:PACKET_WIDTH-1] d_in,
  output logic [0:PACKET_WIDTH-1] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [0:PACKET_WIDTH-1] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [0:PACKET_WIDTH-1] net_do,
  input  logic                    net_polarity
);

  cpu_op_e                 cpu_op;
  logic [0:PACKET_WIDTH-1] in_buf;
  logic [0:PACKET_WIDTH-1] out_buf;
  logic                    in_full;
  logic                    out_full;
  logic                    in_wr;
  logic                    in_clr;
  logic                    out_wr;

  assign cpu_op = decode_op(nicEn, nicEnWR);

  // Router -> CPU channel. A write can never coincide with a clear:
  // the router only writes when empty, the CPU load only matters when full.
  assign net_ri = ~in_full;
  assign in_wr  = net_si & net_ri;
  assign in_clr = (cpu_op == CPU_LOAD) && (addr == ADDR_IN_BUF);

  nic_channel_buf #(.WIDTH(PACKET_WIDTH)) u_in_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_wr),
    .wr_data (net_di),
    .clr     (in_clr),
    .data    (in_buf),
    .full    (in_full)
  );

  // CPU -> router channel. A store while full (including the edge on which
  // the packet leaves) is dropped; the CPU polls the status word instead.
  assign out_wr = (cpu_op == CPU_STORE) && (addr == ADDR_OUT_BUF) && !out_full;

`ifdef NIC_POLARITY_CHECK_EN
  assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign net_so = out_full & net_ro;
`endif

  assign net_do = net_so ? out_buf : '0;

  nic_channel_buf #(.WIDTH(PACKET_WIDTH)) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (out_wr),
    .wr_data (d_in),
    .clr     (net_so),
    .data    (out_buf),
    .full    (out_full)
  );

  // Registered load data; loads of the store-only address leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (cpu_op == CPU_LOAD) begin
      case (addr)
        ADDR_IN_BUF:   d_out <= in_buf;
        ADDR_IN_STAT:  d_out <= {{(PACKET_WIDTH-1){1'b0}}, in_full};
        ADDR_OUT_STAT: d_out <= {{(PACKET_WIDTH-1){1'b0}}, out_full};
        default:       d_out <= d_out;
      endcase
    end
  end

endmodule

// File: tb/tb_nic.sv
// Directed bench for nic: CPU load/store, router handshakes, polarity, reset.
module tb_nic;

  localparam int W = 64;

  localparam logic [0:W-1] P1 = 64'h200200000000FA50;
  localparam logic [0:W-1] P2 = 64'h40100000FFFFFFFF;
  localparam logic [0:W-1] P3 = 64'h1234567812345678;
  localparam logic [0:W-1] ONE = 64'd1;
  localparam logic [0:W-1] ZERO = 64'd0;

  logic         clk;
  logic         reset;
  logic [0:1]   addr;
  logic [0:W-1] d_in;
  logic [0:W-1] d_out;
  logic         nicEn;
  logic         nicEnWR;
  logic         net_si;
  logic         net_ri;
  logic [0:W-1] net_di;
  logic         net_so;
  logic         net_ro;
  logic [0:W-1] net_do;
  logic         net_polarity;

  int total;
  int bad;

  nic #(.PACKET_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWR      (nicEnWR),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_store(input logic [1:0] a, input logic [0:W-1] d);
    nicEn = 1'b1; nicEnWR = 1'b1; addr = a; d_in = d;
    tick();
    nicEn = 1'b0; nicEnWR = 1'b0;
  endtask

  task automatic cpu_load(input logic [1:0] a);
    nicEn = 1'b1; nicEnWR = 1'b0; addr = a;
    tick();
    nicEn = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWR = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

    // Reset then idle
    #12 reset = 1'b1;
    tick(); tick();
    check("rst_d_out",  d_out,  ZERO);
    check("rst_net_ri", net_ri, 1);
    check("rst_net_so", net_so, 0);
    check("rst_net_do", net_do, ZERO);

    // Send in the polarity-0 cycle
    net_ro = 1'b1; net_polarity = 1'b0;
    cpu_store(2'b10, P1);
    check("tx0_so", net_so, 1);
    check("tx0_do", net_do, P1);
    tick();
    check("tx0_so_clr", net_so, 0);
    check("tx0_do_clr", net_do, ZERO);
    cpu_load(2'b11);
    check("tx0_stat", d_out, ZERO);

    // Wrong polarity held, then toggled
    net_polarity = 1'b1;
    cpu_store(2'b10, P1);
`ifdef NIC_POLARITY_CHECK_EN
    check("pol1_so", net_so, 0);
    check("pol1_do", net_do, ZERO);
    cpu_load(2'b11);
    check("pol1_stat", d_out, ONE);
    net_polarity = 1'b0;
    #1;
    check("pol0_so", net_so, 1);
    check("pol0_do", net_do, P1);
    tick();
    check("pol0_so_clr", net_so, 0);
`else
    check("nopol_so", net_so, 1);
    check("nopol_do", net_do, P1);
    tick();
    check("nopol_so_clr", net_so, 0);
    cpu_load(2'b11);
    check("nopol_stat", d_out, ZERO);
    net_polarity = 1'b0;
`endif

    // Router delivers a packet to the CPU
    net_si = 1'b1; net_di = P2;
    tick();
    net_si = 1'b0; net_di = P3;
    check("rx_ri_low", net_ri, 0);
    cpu_load(2'b01);
    check("rx_stat", d_out, ONE);
    check("rx_ri_still_low", net_ri, 0);
    cpu_load(2'b00);
    check("rx_data", d_out, P2);
    check("rx_ri_high", net_ri, 1);
    cpu_load(2'b01);
    check("rx_stat_clr", d_out, ZERO);
    cpu_load(2'b00);
    check("rx_stale", d_out, P2);
    cpu_load(2'b10);
    check("load_10_hold", d_out, P2);

    // Ignored stores to non-output addresses
    cpu_store(2'b00, P3);
    check("st00_so", net_so, 0);
    cpu_load(2'b11);
    check("st00_stat", d_out, ZERO);

    // Second store while full is dropped
    net_ro = 1'b0;
    cpu_store(2'b10, P1);
    cpu_store(2'b10, P3);
    check("drop_so", net_so, 0);
    check("drop_do", net_do, ZERO);
    cpu_load(2'b11);
    check("drop_stat", d_out, ONE);
    net_ro = 1'b1;
    #1;
    check("drop_so_first", net_so, 1);
    check("drop_do_first", net_do, P1);
    tick();
    check("drop_so_clr", net_so, 0);

    // Reset with both buffers full
    net_ro = 1'b0;
    cpu_store(2'b10, P1);
    net_si = 1'b1; net_di = P2;
    tick();
    net_si = 1'b0;
    cpu_load(2'b01);
    check("full_in_stat", d_out, ONE);
    cpu_load(2'b11);
    check("full_out_stat", d_out, ONE);
    reset = 1'b0;
    net_ro = 1'b1;
    #1;
    check("mrst_so", net_so, 0);
    check("mrst_ri", net_ri, 1);
    check("mrst_d_out", d_out, ZERO);
    #1 reset = 1'b1;
    tick();
    check("mrst_so_after", net_so, 0);
    cpu_load(2'b01);
    check("mrst_in_stat", d_out, ZERO);
    cpu_load(2'b11);
    check("mrst_out_stat", d_out, ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nic.md
Name: nic

Overview:
- Network interface controller between a processing-element CPU port and one mesh router PE port.
- Holds one single-entry input channel buffer (router -> CPU) and one single-entry output channel buffer (CPU -> router).
- Each buffer has a 1-bit full status.
- CPU accesses are memory-mapped with a 2-bit address. Router side uses a send/ready handshake gated by the router's even/odd polarity.

Parameters:
- PACKET_WIDTH, 64, packet/data width in bits; bit indexing is [0:PACKET_WIDTH-1], bit 0 = MSB.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  [0:1]  CPU register address
- d_in  in  [0:PACKET_WIDTH-1]  CPU store data
- d_out  out  [0:PACKET_WIDTH-1]  CPU load data, registered
- nicEn  in  1  CPU access enable
- nicEnWR  in  1  1 = store, 0 = load (qualified by nicEn)
- net_si  in  1  router has a packet for the NIC on net_di
- net_ri  out  1  NIC input buffer can accept a packet
- net_di  in  [0:PACKET_WIDTH-1]  packet from router
- net_so  out  1  NIC presents a packet on net_do
- net_ro  in  1  router PE input can accept a packet
- net_do  out  [0:PACKET_WIDTH-1]  packet to router
- net_polarity  in  1  router's current cycle polarity (0 = even, 1 = odd)

Behaviour:
- Reset (reset = 0, async):
  - in_full = 0, out_full = 0, both buffers = 0, d_out = 0.
  - Consequently net_ri = 1, net_so = 0, net_do = 0.
- Address map:
  - 00: input buffer, load only.
  - 01: input status, load only.
  - 10: output buffer, store only.
  - 11: output status, load only.
- Load (nicEn = 1, nicEnWR = 0), 1-cycle latency:
  - addr 00: d_out <= in_buf; in_full <= 0. If in_full was already 0, d_out still takes the stale in_buf value.
  - addr 01: d_out <= {zeros, in_full} (LSB = status).
  - addr 11: d_out <= {zeros, out_full}.
  - addr 10 load: ignored; d_out holds.
- Store (nicEn = 1, nicEnWR = 1):
  - Only addr 10 is valid. If out_full = 0: out_buf <= d_in, out_full <= 1.
  - If out_full = 1: store dropped, no state change.
  - Stores to 00/01/11: ignored.
- nicEn = 0: no CPU effect; d_out holds.
- Router -> NIC:
  - net_ri = ~in_full (combinational).
  - On an edge with net_si & net_ri: in_buf <= net_di, in_full <= 1.
  - net_si while full: ignored (router must hold).
- NIC -> router:
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity) (combinational).
  - net_do = out_buf when net_so = 1, else 0.
  - On an edge with net_so = 1: out_full <= 0; out_buf retained but not visible on net_do.
- Simultaneous events, same edge:
  - CPU load of addr 00 while router writes: cannot occur, since net_ri = 0 when in_full = 1. Load clears full; the router may write on the next edge.
  - CPU store while net_so = 1: store is dropped (out_full sampled as 1). The CPU must poll addr 11.
- Reset mid-operation discards both buffered packets immediately.

Optional Feature:
- Macro NIC_POLARITY_CHECK_EN.
- Defined: injection requires out_buf[0] (VC bit) == net_polarity, as above.
- Undefined: the polarity term is removed: net_so = out_full & net_ro. net_polarity is left unused.

Decomposition:
- Package nic_pkg:
  - address constants ADDR_IN_BUF = 2'b00, ADDR_IN_STAT = 2'b01, ADDR_OUT_BUF = 2'b10, ADDR_OUT_STAT = 2'b11.
  - VC_BIT = 0.
  - Default PACKET_WIDTH.
- Sub-module nic_channel_buf: a PACKET_WIDTH data register plus full flag, with write/clear controls. Instantiated twice (input and output channels).

Test Plan:
- Reset low, then high; no activity -> d_out = 0, net_ri = 1, net_so = 0, net_do = 0.
- Store addr 10, d_in = 0x200200000000FA50, with net_ro = 1 and net_polarity = 0 -> out_full = 1. net_so = 1 and net_do = 0x200200000000FA50 in the polarity-0 cycle. out_full clears on the following edge. A load of addr 11 then returns 0.
- Same packet with net_polarity = 1 held -> net_so stays 0 and a load of addr 11 returns 1. Toggle polarity to 0 -> packet sent. With NIC_POLARITY_CHECK_EN undefined, the packet is sent immediately.
- Router drives net_si = 1, net_di = 0x40100000FFFFFFFF -> net_ri falls to 0 and a load of addr 01 returns 1. A load of addr 00 returns 0x40100000FFFFFFFF and net_ri returns to 1.
- Second store to addr 10 while out_full = 1 with net_ro = 0 -> original out_buf is kept and the later net_do shows the first packet only.
- Reset asserted while both buffers are full -> both status loads return 0 and net_so = 0 immediately.
